// File: rtl/serial_paralelo_param.sv
// Serial-to-parallel receiver with comma alignment, lock qualification and
// loss-of-lock recovery. Bits arrive MSB first on clk_32f. The receiver locks
// its word boundary after LOCK_COUNT consecutive aligned commas, then emits
// every non-comma word on data_out with a one-cycle valid_out strobe.
module serial_paralelo_param #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int               LOCK_COUNT = 4,
  parameter int               LOSS_COUNT = 2,
  parameter int               CNT_W      = 4
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active,
  output logic [CNT_W-1:0] BC_counter
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LOCK_L   = CNT_W'(LOCK_COUNT);
  localparam logic [3:0]       LOSS_L   = 4'(LOSS_COUNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t           state;
  // Only the previous WIDTH-1 bits are kept; the oldest bit of a full word
  // register would never be looked at again.
  logic [WIDTH-2:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [3:0]       miss_cnt;

  logic [WIDTH-1:0] cand;
  logic             comma_hit;
  logic             boundary;
  logic [BW-1:0]    bit_cnt_nxt;
  logic [CNT_W-1:0] bc_nxt;
  logic [3:0]       miss_nxt;

  // Candidate word formed by the bit arriving on this edge plus history
  assign cand        = {shreg, data_in};
  assign comma_hit   = (cand == COMMA);
  assign boundary    = (bit_cnt == LAST_BIT);
  assign bit_cnt_nxt = boundary ? '0 : bit_cnt + BW'(1);
  assign bc_nxt      = BC_counter + CNT_W'(1);
  assign miss_nxt    = miss_cnt + 4'd1;

  // Shift register, alignment FSM and all registered outputs
  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state      <= SEARCH;
      shreg      <= '0;
      bit_cnt    <= '0;
      miss_cnt   <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      active     <= 1'b0;
      BC_counter <= '0;
    end else begin
      shreg <= cand[WIDTH-2:0];
      case (state)
        SEARCH: begin
          bit_cnt   <= '0;
          miss_cnt  <= '0;
          valid_out <= 1'b0;
          active    <= 1'b0;
          if (comma_hit) begin
            BC_counter <= CNT_W'(1);
            if (LOCK_COUNT == 1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end

        ALIGN: begin
          valid_out <= 1'b0;
          bit_cnt   <= bit_cnt_nxt;
          if (boundary) begin
            if (comma_hit) begin
              BC_counter <= bc_nxt;
              if (bc_nxt == LOCK_L) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              state      <= SEARCH;
              BC_counter <= '0;
              bit_cnt    <= '0;
            end
          end
        end

        ACTIVE: begin
          bit_cnt <= bit_cnt_nxt;
          if (boundary) begin
            if (comma_hit) begin
              // Aligned filler comma: confirms lock, carries no data
              valid_out <= 1'b0;
              miss_cnt  <= '0;
            end else begin
              data_out  <= cand;
              valid_out <= 1'b1;
            end
          end else begin
            valid_out <= 1'b0;
            if (comma_hit) begin
              // Comma off the locked boundary: phase may have slipped.
              // The triggering comma is not reused; SEARCH restarts next edge.
              if (miss_nxt == LOSS_L) begin
                state      <= SEARCH;
                active     <= 1'b0;
                BC_counter <= '0;
                miss_cnt   <= '0;
                bit_cnt    <= '0;
              end else begin
                miss_cnt <= miss_nxt;
              end
            end
          end
        end

        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Bench for serial_paralelo_param: a default 8-bit instance and a 10-bit,
// comma 0x17C, LOCK_COUNT=2 instance. Word-level vectors are kept in a table;
// reset sequences are written out by hand.
module tb_serial_paralelo_param;

  logic       clk = 1'b0;
  logic       rst8_l, din8;
  logic       rst10_l, din10;
  logic [7:0] dout8;
  logic       vld8, act8;
  logic [3:0] bc8;
  logic [9:0] dout10;
  logic       vld10, act10;
  logic [3:0] bc10;

  int n_cmp  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  serial_paralelo_param dut8 (
    .clk_32f    (clk),
    .reset_L    (rst8_l),
    .data_in    (din8),
    .data_out   (dout8),
    .valid_out  (vld8),
    .active     (act8),
    .BC_counter (bc8)
  );

  serial_paralelo_param #(
    .WIDTH      (10),
    .COMMA      (10'h17C),
    .LOCK_COUNT (2),
    .LOSS_COUNT (2),
    .CNT_W      (4)
  ) dut10 (
    .clk_32f    (clk),
    .reset_L    (rst10_l),
    .data_in    (din10),
    .data_out   (dout10),
    .valid_out  (vld10),
    .active     (act10),
    .BC_counter (bc10)
  );

  typedef struct {
    bit          sel10;
    int          nbits;
    logic [15:0] word;
    bit          chk_mid;
    logic        exp_v;
    logic [15:0] exp_d;
    logic        exp_a;
    logic [3:0]  exp_bc;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit sel10, int nbits, logic [15:0] word, bit chk_mid,
                              logic ev, logic [15:0] ed, logic ea, logic [3:0] ebc,
                              string name);
    vec_t v;
    v.sel10 = sel10; v.nbits = nbits; v.word = word; v.chk_mid = chk_mid;
    v.exp_v = ev; v.exp_d = ed; v.exp_a = ea; v.exp_bc = ebc; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(logic r8, logic d8, logic r10, logic d10);
    @(negedge clk);
    rst8_l = r8; din8 = d8; rst10_l = r10; din10 = d10;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(string name, bit sel10, logic v, logic [15:0] d, logic a,
                          logic [3:0] bc);
    if (sel10) begin
      chk({name, ".valid"},  {15'b0, vld10}, {15'b0, v});
      chk({name, ".data"},   {6'b0, dout10}, d);
      chk({name, ".active"}, {15'b0, act10}, {15'b0, a});
      chk({name, ".bc"},     {12'b0, bc10},  {12'b0, bc});
    end else begin
      chk({name, ".valid"},  {15'b0, vld8},  {15'b0, v});
      chk({name, ".data"},   {8'b0, dout8},  d);
      chk({name, ".active"}, {15'b0, act8},  {15'b0, a});
      chk({name, ".bc"},     {12'b0, bc8},   {12'b0, bc});
    end
  endtask

  task automatic run_vec(vec_t v);
    logic b;
    logic mid_hi;
    mid_hi = 1'b0;
    for (int i = 0; i < v.nbits; i++) begin
      b = v.word[v.nbits-1-i];
      if (v.sel10) tick(1'b0, 1'b0, 1'b1, b);
      else         tick(1'b1, b, 1'b0, 1'b0);
      if (i < v.nbits - 1) begin
        if (v.sel10 ? vld10 : vld8) mid_hi = 1'b1;
      end
    end
    if (v.chk_mid) chk({v.name, ".mid_valid"}, {15'b0, mid_hi}, 16'h0);
    chk_outs(v.name, v.sel10, v.exp_v, v.exp_d, v.exp_a, v.exp_bc);
  endtask

  initial begin
    rst8_l = 1'b0; din8 = 1'b0; rst10_l = 1'b0; din10 = 1'b0;

    // ---- 8-bit instance vectors ----
    add(0, 8, 16'h00,  1, 0, 16'h00, 0, 4'd0, "post_rst_00");
    add(0, 8, 16'hBC,  1, 0, 16'h00, 0, 4'd1, "fl_bc1");
    add(0, 8, 16'hBC,  1, 0, 16'h00, 0, 4'd2, "fl_bc2");
    add(0, 8, 16'hBC,  1, 0, 16'h00, 0, 4'd3, "fl_bc3");
    add(0, 8, 16'h55,  1, 0, 16'h00, 0, 4'd0, "fl_55");
    add(0, 7, 16'h00,  1, 0, 16'h00, 0, 4'd0, "zeros7");
    add(0, 8, 16'hBC,  1, 0, 16'h00, 0, 4'd1, "lk_bc1");
    add(0, 8, 16'hBC,  1, 0, 16'h00, 0, 4'd2, "lk_bc2");
    add(0, 8, 16'hBC,  1, 0, 16'h00, 0, 4'd3, "lk_bc3");
    add(0, 8, 16'hBC,  1, 0, 16'h00, 1, 4'd4, "lk_bc4");
    add(0, 8, 16'hFF,  1, 1, 16'hFF, 1, 4'd4, "dat_ff");
    add(0, 8, 16'hEE,  1, 1, 16'hEE, 1, 4'd4, "dat_ee");
    add(0, 8, 16'hA5,  1, 1, 16'hA5, 1, 4'd4, "fil_a5");
    add(0, 8, 16'hBC,  1, 0, 16'hA5, 1, 4'd4, "fil_bc1");
    add(0, 8, 16'hBC,  1, 0, 16'hA5, 1, 4'd4, "fil_bc2");
    add(0, 8, 16'h3C,  1, 1, 16'h3C, 1, 4'd4, "fil_3c");
    add(0, 1, 16'h00,  1, 0, 16'h3C, 1, 4'd4, "slip_bit");
    // Shifted phase: the locked boundary now sees 0x5E, commas land off it
    add(0, 8, 16'hBC,  0, 0, 16'h5E, 1, 4'd4, "loss_bc1");
    add(0, 8, 16'hBC,  0, 0, 16'h5E, 0, 4'd0, "loss_bc2");
    add(0, 8, 16'hBC,  1, 0, 16'h5E, 0, 4'd1, "rl_bc1");
    add(0, 8, 16'hBC,  1, 0, 16'h5E, 0, 4'd2, "rl_bc2");
    add(0, 8, 16'hBC,  1, 0, 16'h5E, 0, 4'd3, "rl_bc3");
    add(0, 8, 16'hBC,  1, 0, 16'h5E, 1, 4'd4, "rl_bc4");
    add(0, 8, 16'h12,  1, 1, 16'h12, 1, 4'd4, "rl_12");
    // ---- 10-bit instance vectors ----
    add(1, 10, 16'h17C, 1, 0, 16'h000, 0, 4'd1, "w10_c1");
    add(1, 10, 16'h17C, 1, 0, 16'h000, 1, 4'd2, "w10_c2");
    add(1, 10, 16'h155, 1, 1, 16'h155, 1, 4'd2, "w10_155");

    // Reset held for 3 edges with data toggling
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, k[0], 1'b0, ~k[0]);
      chk_outs($sformatf("rst8_e%0d", k), 1'b0, 1'b0, 16'h0, 1'b0, 4'd0);
      chk_outs($sformatf("rst10_e%0d", k), 1'b1, 1'b0, 16'h0, 1'b0, 4'd0);
    end

    // 8-bit instance: all of its table rows
    for (int i = 0; i < vecs.size(); i++)
      if (!vecs[i].sel10) run_vec(vecs[i]);

    // 10-bit instance: lock, one data word
    for (int i = 0; i < vecs.size(); i++)
      if (vecs[i].sel10) run_vec(vecs[i]);

    // Reset between bits 3 and 4 of a word while ACTIVE
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk_outs("w10_midrst", 1'b1, 1'b0, 16'h0, 1'b0, 4'd0);

    // Relock after release and deliver 0x2AA
    vecs.delete();
    add(1, 10, 16'h17C, 1, 0, 16'h000, 0, 4'd1, "w10_r_c1");
    add(1, 10, 16'h17C, 1, 0, 16'h000, 1, 4'd2, "w10_r_c2");
    add(1, 10, 16'h2AA, 1, 1, 16'h2AA, 1, 4'd2, "w10_r_2aa");
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Strobe lasts exactly one cycle
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("w10_strobe_drop", {15'b0, vld10}, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_param.md
Name: serial_paralelo_param

Overview:
- Parametrised serial-to-parallel receiver with comma (BC) alignment, lock qualification and loss-of-lock recovery.
- Runs on the serial bit clock and shifts in data_in MSB first.
- Locks word boundaries after LOCK_COUNT consecutive aligned commas, then delivers non-comma words on data_out with a one-cycle valid_out strobe.
- Replaces the fixed 8-bit/0xBC receiver; adds width, comma, lock-depth and loss-of-lock generalisation.

Parameters:
- WIDTH, 8, word width in bits (4..16).
- COMMA, 8'hBC, alignment symbol, WIDTH bits.
- LOCK_COUNT, 4, consecutive aligned commas required to assert active (1..2^CNT_W-1).
- LOSS_COUNT, 2, misaligned comma detections in ACTIVE that force resynchronisation (1..15).
- CNT_W, 4, width of BC_counter.

Ports:
- clk_32f  input  1  serial bit clock; all logic on posedge.
- reset_L  input  1  synchronous reset, active-low.
- data_in  input  1  serial data, MSB first.
- data_out  output  WIDTH  last received non-comma word.
- valid_out  output  1  one-cycle strobe, data_out updated this cycle.
- active  output  1  receiver locked.
- BC_counter  output  CNT_W  aligned commas counted toward lock.

Behaviour:
- Single clock domain, clk_32f. Reset is synchronous, active-low (reset_L).
- Reset:
  - reset_L=0 at a posedge clears shreg, bit_cnt, miss_cnt, data_out, valid_out, active and BC_counter to 0, and sets state=SEARCH.
  - Reset overrides everything, including mid-word or while ACTIVE.
- Shifting: every posedge with reset_L=1, shreg <= {shreg[WIDTH-2:0], data_in}. Define cand = {shreg[WIDTH-2:0], data_in}.
- Boundary: a word boundary is a posedge where bit_cnt==WIDTH-1. bit_cnt wraps WIDTH-1 -> 0.
- All outputs are registered. A word is visible the cycle after the edge that samples its LSB.
- SEARCH:
  - bit_cnt is held at 0 and active=0.
  - If cand==COMMA: bit_cnt<=0, BC_counter<=1, go to ALIGN (LOCK_COUNT==1 goes straight to ACTIVE with active<=1).
- ALIGN:
  - bit_cnt increments every cycle.
  - Boundary with cand==COMMA: BC_counter+1. On reaching LOCK_COUNT, go to ACTIVE and active<=1 on the same edge.
  - Boundary with cand!=COMMA: go to SEARCH, BC_counter<=0.
  - Non-boundary cycles: no comma check.
- ACTIVE, at a boundary:
  - cand==COMMA: valid_out<=0, data_out holds, miss_cnt<=0, BC_counter holds (saturated at LOCK_COUNT).
  - cand!=COMMA: data_out<=cand, valid_out<=1.
- ACTIVE, off boundary:
  - valid_out<=0.
  - If cand==COMMA (misaligned comma), miss_cnt+1.
  - When miss_cnt+1==LOSS_COUNT: go to SEARCH, active<=0, BC_counter<=0, miss_cnt<=0, bit_cnt<=0. data_out holds its last value.
- Simultaneous events:
  - A misaligned comma that triggers loss is not itself used for realignment. SEARCH starts checking on the next edge.
  - valid_out is never asserted on the cycle active falls.
- Always:
  - valid_out=0 outside ACTIVE.
  - valid_out is never high on two consecutive cycles when WIDTH>1.

Test Plan:
- Reset: hold reset_L=0 for 3 edges with data_in toggling -> data_out=0, valid_out=0, active=0, BC_counter=0 at each edge. Release, then send 0x00 -> no change.
- Lock and data (defaults):
  - Stimulus: 7 zero bits, 4×0xBC (10111100, MSB first), then 0xFF, 0xEE.
  - BC_counter steps 1,2,3,4 at 8-cycle intervals.
  - active rises with the 4th BC's LSB.
  - valid_out pulses for 1 cycle with data_out=0xFF, then 8 cycles later with data_out=0xEE.
- Failed lock: 3×0xBC, then 0x55 -> BC_counter returns to 0 at the 0x55 boundary, active stays 0, valid_out never asserts.
- Comma filler in ACTIVE: after lock, send 0xA5, 0xBC, 0xBC, 0x3C -> valid_out pulses with 0xA5, none for the two BCs (data_out stays 0xA5), then pulses with 0x3C.
- Loss and relock:
  - After lock, insert one extra bit, then a continuous BC stream.
  - active falls at the 2nd misaligned comma detection and BC_counter=0.
  - The receiver realigns on the new phase and active rises again after 4 aligned BCs.
- Reset mid-ACTIVE, and WIDTH=10, COMMA=10'h17C, LOCK_COUNT=2:
  - reset_L=0 between bits 3 and 4 of a word clears all outputs on that edge.
  - After release, 2×0x17C then 0x2AA -> active=1, valid_out pulses with data_out=10'h2AA.
